// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: state encoding, CONFIG/STATE register fields and command codes
// shared by the SPI transaction sequencer files.
`default_nettype none

package spi_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CFG      = 4'd1,
    ST_LOAD     = 4'd2,
    ST_START    = 4'd3,
    ST_POLL_RD  = 4'd4,
    ST_POLL_CHK = 4'd5,
    ST_RX_RD    = 4'd6,
    ST_RX_CAP   = 4'd7,
    ST_DONE     = 4'd8,
    ST_ABORT    = 4'd9
  } state_t;

  localparam int CFG_MODE_LSB  = 0;
  localparam int CFG_SLAVE_LSB = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_RX_DONE = 1;

  localparam logic [7:0] CMD_START_VAL = 8'h01;

  function automatic logic [7:0] cfg_byte(input logic [1:0] slave, input logic [1:0] mode);
    logic [7:0] b;
    b = 8'h00;
    b[CFG_SLAVE_LSB +: 2] = slave;
    b[CFG_MODE_LSB +: 2]  = mode;
    return b;
  endfunction

  function automatic logic status_ready(input logic [7:0] status);
    return !status[STAT_BUSY] && status[STAT_RX_DONE];
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_seq_wdog.sv
// spi_seq_wdog: counts unsuccessful status polls of one byte and flags the
// poll that reaches TIMEOUT_CYCLES.
`default_nettype none

module spi_seq_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  // Fires on the poll that would bring the count up to TIMEOUT_CYCLES.
  assign expired = inc && (count == LIMIT);

endmodule

`default_nettype wire

// File: rtl/spi_txn_sequencer.sv
// spi_txn_sequencer: drives an SPI master register port through config, per-byte
// load/start/poll/read. Optional poll watchdog enabled by SPI_SEQ_WDOG_EN.
`default_nettype none

module spi_txn_sequencer
  import spi_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  CMD_START      = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_slave,
  input  logic [1:0] req_mode,
  input  logic [3:0] req_len,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       done,
  output logic       err,
  output logic       WR0,
  output logic       WR1,
  output logic       WR2,
  output logic       WR3,
  output logic       DR0,
  output logic       DR1,
  output logic       DR2,
  output logic       DR3,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA
);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] slave_q;
  logic [1:0] mode_q;
  logic [3:0] rem_q;
  logic [7:0] rx_data_q;
  logic       wdog_expired;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("spi_txn_sequencer: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef SPI_SEQ_WDOG_EN
  spi_seq_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == ST_START),
    .inc    ((state == ST_POLL_CHK) && !status_ready(PRDATA)),
    .expired(wdog_expired)
  );
`else
  assign wdog_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      slave_q   <= 2'd0;
      mode_q    <= 2'd0;
      rem_q     <= 4'd0;
      rx_data_q <= 8'h00;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && req_valid) begin
        slave_q <= req_slave;
        mode_q  <= req_mode;
        rem_q   <= req_len;
      end
      if (state == ST_RX_CAP) begin
        rx_data_q <= PRDATA;
        if (rem_q != 4'd0) begin
          rem_q <= rem_q - 4'd1;
        end
      end
    end
  end

  // Captured byte is presented combinationally in RX_CAP and held afterwards.
  assign rx_data = (state == ST_RX_CAP) ? PRDATA : rx_data_q;

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    tx_ready  = 1'b0;
    rx_valid  = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    WR0       = 1'b0;
    WR1       = 1'b0;
    WR2       = 1'b0;
    WR3       = 1'b0;
    DR0       = 1'b0;
    DR1       = 1'b0;
    DR2       = 1'b0;
    DR3       = 1'b0;
    PWDATA    = 8'h00;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ST_CFG;
      end
      ST_CFG: begin
        WR0       = 1'b1;
        PWDATA    = cfg_byte(slave_q, mode_q);
        state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          WR1       = 1'b1;
          PWDATA    = tx_data;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        WR3       = 1'b1;
        PWDATA    = CMD_START;
        state_nxt = ST_POLL_RD;
      end
      ST_POLL_RD: begin
        DR0       = 1'b1;
        state_nxt = ST_POLL_CHK;
      end
      ST_POLL_CHK: begin
        if (status_ready(PRDATA)) begin
          state_nxt = ST_RX_RD;
        end else if (wdog_expired) begin
          state_nxt = ST_ABORT;
        end else begin
          state_nxt = ST_POLL_RD;
        end
      end
      ST_RX_RD: begin
        DR1       = 1'b1;
        state_nxt = ST_RX_CAP;
      end
      ST_RX_CAP: begin
        rx_valid  = 1'b1;
        state_nxt = (rem_q != 4'd0) ? ST_LOAD : ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_ABORT: begin
`ifdef SPI_SEQ_WDOG_EN
        err = 1'b1;
`endif
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_txn_sequencer.sv
// tb_spi_txn_sequencer: table-driven and directed checks of spi_txn_sequencer
// against a small register-port responder.
`default_nettype none

module tb_spi_txn_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_slave;
  logic [1:0] req_mode;
  logic [3:0] req_len;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       done;
  logic       err;
  logic       WR0, WR1, WR2, WR3, DR0, DR1, DR2, DR3;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;

  spi_txn_sequencer #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_slave(req_slave), .req_mode(req_mode), .req_len(req_len),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .done(done), .err(err),
    .WR0(WR0), .WR1(WR1), .WR2(WR2), .WR3(WR3),
    .DR0(DR0), .DR1(DR1), .DR2(DR2), .DR3(DR3),
    .PWDATA(PWDATA), .PRDATA(PRDATA)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Register-port responder: status busy for busy_cfg polls after each start.
  int         busy_cfg = 0;
  logic [7:0] rx_base  = 8'h00;
  int         busy_left;
  int         rx_idx;

  always @(posedge clk) begin
    if (rst) begin
      PRDATA    <= 8'h00;
      busy_left <= 0;
      rx_idx    <= 0;
    end else begin
      if (WR0) rx_idx <= 0;
      if (WR3) busy_left <= busy_cfg;
      if (DR0) begin
        if (busy_left > 0) begin
          PRDATA    <= 8'h01;
          busy_left <= busy_left - 1;
        end else begin
          PRDATA <= 8'h02;
        end
      end else if (DR1) begin
        PRDATA <= rx_base + 8'(rx_idx);
        rx_idx <= rx_idx + 1;
      end
    end
  end

  function automatic logic [28:0] outs();
    return {req_ready, tx_ready, rx_valid, done, err,
            WR0, WR1, WR2, WR3, DR0, DR1, DR2, DR3, PWDATA, rx_data};
  endfunction

  localparam logic [28:0] IDLE_OUTS = 29'h1000_0000;

  typedef struct {
    int          acc, fin;
    int          wr0_n, wr1_n, wr1_bad, wr3_n, wr3_bad;
    int          rx_n, rx_bad, done_n, err_n, done_cyc, err_cyc;
    int          first_wr1, first_rx, proto_bad, stall_bad, post_ready;
    logic [7:0]  wr0_val, post_rx;
    logic [28:0] post_rst;
  } res_t;

  task automatic run_req(input logic [1:0] s, input logic [1:0] m, input logic [3:0] l,
                         input int busy, input int stall_byte, input int stall_n,
                         input int rst_byte, input int budget,
                         input logic [7:0] txb, input logic [7:0] rxb, output res_t r);
    int   tx_idx, stall_left, nbytes;
    logic rst_pend, junk;
    logic [7:0] e;
    r = '{default: 0};
    busy_cfg   = busy;
    rx_base    = rxb;
    tx_idx     = 0;
    stall_left = stall_n;
    nbytes     = int'(l) + 1;
    rst_pend   = 1'b0;
    @(negedge clk);
    req_slave = s; req_mode = m; req_len = l; req_valid = 1'b1;
    #1 r.acc = int'(req_ready);
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (rst_pend) begin
        rst = 1'b1; tx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1 r.post_rst = outs();
        break;
      end
      junk     = (tx_idx == stall_byte) && (stall_left > 0);
      tx_valid = (tx_idx < nbytes) && !junk;
      tx_data  = txb + 8'(tx_idx);
      if (junk) begin
        req_valid = 1'b1;
        req_slave = ~s;
      end
      #1;
      if ($countones({WR0, WR1, WR2, WR3, DR0, DR1, DR2, DR3}) > 1 || WR2 || DR2 || DR3)
        r.proto_bad++;
      if (junk && req_ready) r.stall_bad++;
      if (junk && tx_ready) begin
        stall_left--;
        if ({WR0, WR1, WR2, WR3, DR0, DR1, DR2, DR3} != 8'h00) r.stall_bad++;
      end
      if (WR0) begin r.wr0_n++; r.wr0_val = PWDATA; end
      if (WR1) begin
        e = txb + 8'(tx_idx);
        if (PWDATA !== e) r.wr1_bad++;
        if (r.wr1_n == 0) r.first_wr1 = c;
        r.wr1_n++;
        tx_idx++;
      end
      if (WR3) begin
        r.wr3_n++;
        if (PWDATA !== 8'h01) r.wr3_bad++;
      end
      if (rx_valid) begin
        e = rxb + 8'(r.rx_n);
        if (rx_data !== e) r.rx_bad++;
        if (r.rx_n == 0) r.first_rx = c;
        r.rx_n++;
      end
      if (err)  begin r.err_n++;  r.err_cyc  = c; end
      if (done) begin r.done_n++; r.done_cyc = c; end
      if (DR0 && r.wr3_n == rst_byte) rst_pend = 1'b1;
      if (done || err) begin r.fin = 1; break; end
    end
    tx_valid  = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    r.post_ready = int'(req_ready);
    r.post_rx    = rx_data;
  endtask

  typedef struct {
    logic [1:0] slave, mode;
    logic [3:0] len;
    int         busy;
    logic [7:0] exp_cfg;
    int         exp_bytes;
    int         exp_done_cyc;
  } vec_t;

  vec_t vecs[5];
  res_t r;

  initial begin
    // done cycle = 2 + bytes * (6 + 2*busy)
    vecs[0] = '{2'd0, 2'd0, 4'd0,  0, 8'h00,  1,  8};
    vecs[1] = '{2'd3, 2'd2, 4'd3,  5, 8'h0E,  4, 66};
    vecs[2] = '{2'd1, 2'd3, 4'd15, 0, 8'h07, 16, 98};
    vecs[3] = '{2'd2, 2'd1, 4'd1,  1, 8'h09,  2, 18};
    vecs[4] = '{2'd0, 2'd1, 4'd7,  2, 8'h01,  8, 82};

    rst = 1'b1; req_valid = 1'b0; req_slave = 2'd0; req_mode = 2'd0; req_len = 4'd0;
    tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    #1 check("reset_outputs", 32'(outs()), 32'(IDLE_OUTS));
    rst = 1'b0;

    // Single byte, first poll ready.
    run_req(2'd0, 2'd0, 4'd0, 0, -1, 0, -1, 200, 8'hA5, 8'hF0, r);
    check("basic_finished", r.fin, 1);
    check("basic_cfg", r.wr0_val, 8'h00);
    check("basic_wr1_count", r.wr1_n, 1);
    check("basic_wr1_data", r.wr1_bad, 0);
    check("basic_wr3", r.wr3_n * 256 + r.wr3_bad, 256);
    check("basic_rx", r.rx_n * 256 + r.rx_bad, 256);
    check("basic_latency", r.first_rx - r.first_wr1, 5);
    check("basic_done_after_rx", r.done_cyc - r.first_rx, 1);
    check("basic_rx_hold", r.post_rx, 8'hF0);
    check("basic_ready_after", r.post_ready, 1);

    for (int i = 0; i < 5; i++) begin
      run_req(vecs[i].slave, vecs[i].mode, vecs[i].len, vecs[i].busy, -1, 0, -1, 400,
              8'h10 + 8'(i * 32), 8'h80 + 8'(i * 16), r);
      check($sformatf("v%0d_accept", i), r.acc, 1);
      check($sformatf("v%0d_finished", i), r.fin, 1);
      check($sformatf("v%0d_cfg_writes", i), r.wr0_n, 1);
      check($sformatf("v%0d_cfg", i), r.wr0_val, vecs[i].exp_cfg);
      check($sformatf("v%0d_wr1_count", i), r.wr1_n, vecs[i].exp_bytes);
      check($sformatf("v%0d_wr1_data", i), r.wr1_bad, 0);
      check($sformatf("v%0d_wr3_count", i), r.wr3_n, vecs[i].exp_bytes);
      check($sformatf("v%0d_wr3_data", i), r.wr3_bad, 0);
      check($sformatf("v%0d_rx_count", i), r.rx_n, vecs[i].exp_bytes);
      check($sformatf("v%0d_rx_data", i), r.rx_bad, 0);
      check($sformatf("v%0d_done_err", i), r.done_n * 16 + r.err_n, 16);
      check($sformatf("v%0d_done_cycle", i), r.done_cyc, vecs[i].exp_done_cyc);
      check($sformatf("v%0d_protocol", i), r.proto_bad, 0);
    end

    // tx withheld 20 cycles in LOAD of byte 1, with a stray req_valid meanwhile.
    run_req(2'd1, 2'd0, 4'd1, 0, 1, 20, -1, 200, 8'h11, 8'h22, r);
    check("stall_finished", r.fin, 1);
    check("stall_quiet", r.stall_bad, 0);
    check("stall_cfg_writes", r.wr0_n, 1);
    check("stall_done_cycle", r.done_cyc, 34);
    check("stall_rx", r.rx_n * 256 + r.rx_bad, 2 * 256);
    check("stall_wr1_data", r.wr1_bad, 0);

    // Reset during POLL_CHK of byte 2 of 4, then a fresh request.
    run_req(2'd2, 2'd3, 4'd3, 1, -1, 0, 2, 200, 8'h40, 8'h60, r);
    check("rst_no_done_err", r.done_n + r.err_n, 0);
    check("rst_bytes_before", r.rx_n, 1);
    check("rst_outputs", 32'(r.post_rst), 32'(IDLE_OUTS));
    run_req(2'd2, 2'd3, 4'd3, 1, -1, 0, -1, 200, 8'h40, 8'h60, r);
    check("post_rst_finished", r.fin, 1);
    check("post_rst_cfg", r.wr0_val, 8'h0B);
    check("post_rst_rx", r.rx_n * 256 + r.rx_bad, 4 * 256);
    check("post_rst_done_cycle", r.done_cyc, 34);

    // Status stuck busy.
`ifdef SPI_SEQ_WDOG_EN
    run_req(2'd0, 2'd0, 4'd0, 1000000, -1, 0, -1, 200, 8'h33, 8'h44, r);
    check("wdog_err", r.err_n, 1);
    check("wdog_err_cycle", r.err_cyc, 36);
    check("wdog_no_done_rx", r.done_n + r.rx_n, 0);
    check("wdog_ready_after", r.post_ready, 1);
`else
    run_req(2'd0, 2'd0, 4'd0, 1000000, -1, 0, -1, 150, 8'h33, 8'h44, r);
    check("stuck_still_polling", r.fin, 0);
    check("stuck_no_err", r.err_n, 0);
    check("stuck_no_done_rx", r.done_n + r.rx_n, 0);
    check("stuck_protocol", r.proto_bad, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
